// File: rtl/axil_master_ctrl_if.sv
// AXI4-Lite bus bundle shared by masters and slave register blocks.
// Master drives the request channels and the B/R ready signals; Slave is the mirror image.
interface AXI_LITE #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  modport Master (
    output aw_addr, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport Slave (
    input aw_addr, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/axil_master_ctrl.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI-Lite transaction, one response out.
// Define AXIL_MASTER_TIMEOUT_EN to add a B/R wait timeout that drains the late response afterwards.
module axil_master_ctrl #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]            rsp_resp_o,
  AXI_LITE.Master               axi_l
);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
    $error("axil_master_ctrl: DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("axil_master_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  we_q;
  logic                  aw_valid_q, w_valid_q, aw_done, w_done;
  logic                  b_ready_q, ar_valid_q, r_ready_q;
  logic                  cmd_ready_q, rsp_valid_q, rsp_we_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = aw_valid_q & axi_l.aw_ready;
  assign w_hs  = w_valid_q  & axi_l.w_ready;
  assign b_hs  = b_ready_q  & axi_l.b_valid;
  assign ar_hs = ar_valid_q & axi_l.ar_ready;
  assign r_hs  = r_ready_q  & axi_l.r_valid;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wait_cnt;
  logic             drain_pend;
  logic             wait_expired;
  // The cycle holding TIMEOUT_CYCLES-1 is the last one spent waiting.
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      we_q        <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
`ifdef AXIL_MASTER_TIMEOUT_EN
      wait_cnt    <= '0;
      drain_pend  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef AXIL_MASTER_TIMEOUT_EN
          if (drain_pend) begin
            cmd_ready_q <= 1'b0;
            b_ready_q   <= 1'b1;
            r_ready_q   <= 1'b1;
            if (b_hs || r_hs) begin
              drain_pend  <= 1'b0;
              b_ready_q   <= 1'b0;
              r_ready_q   <= 1'b0;
              cmd_ready_q <= 1'b1;
            end
          end else
`endif
          if (cmd_valid_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr_i;
            wdata_q     <= cmd_wdata_i;
            wstrb_q     <= cmd_wstrb_i;
            we_q        <= cmd_we_i;
            if (cmd_we_i) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state      <= WR_REQ;
            end else begin
              ar_valid_q <= 1'b1;
              state      <= RD_REQ;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        // AW and W retire independently; either order or the same cycle is fine.
        WR_REQ: begin
          if (aw_hs) aw_valid_q <= 1'b0;
          if (w_hs)  w_valid_q  <= 1'b0;
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            b_ready_q <= 1'b1;
            state     <= WR_RESP;
`ifdef AXIL_MASTER_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end else begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
          end
        end

        WR_RESP: begin
          if (b_hs) begin
            b_ready_q   <= 1'b0;
            rsp_resp_q  <= axi_l.b_resp;
            rsp_rdata_q <= '0;
            rsp_we_q    <= we_q;
            rsp_valid_q <= 1'b1;
            state       <= RSP;
          end
`ifdef AXIL_MASTER_TIMEOUT_EN
          else if (wait_expired) begin
            b_ready_q   <= 1'b0;
            rsp_resp_q  <= 2'b10;
            rsp_rdata_q <= '0;
            rsp_we_q    <= we_q;
            rsp_valid_q <= 1'b1;
            drain_pend  <= 1'b1;
            state       <= RSP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        RD_REQ: begin
          if (ar_hs) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state      <= RD_DATA;
`ifdef AXIL_MASTER_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end
        end

        RD_DATA: begin
          if (r_hs) begin
            r_ready_q   <= 1'b0;
            rsp_resp_q  <= axi_l.r_resp;
            rsp_rdata_q <= axi_l.r_data;
            rsp_we_q    <= we_q;
            rsp_valid_q <= 1'b1;
            state       <= RSP;
          end
`ifdef AXIL_MASTER_TIMEOUT_EN
          else if (wait_expired) begin
            r_ready_q   <= 1'b0;
            rsp_resp_q  <= 2'b10;
            rsp_rdata_q <= '0;
            rsp_we_q    <= we_q;
            rsp_valid_q <= 1'b1;
            drain_pend  <= 1'b1;
            state       <= RSP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        // After a timeout the late B/R readies go up on the way back to IDLE.
        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
`ifdef AXIL_MASTER_TIMEOUT_EN
            if (drain_pend) begin
              cmd_ready_q <= 1'b0;
              b_ready_q   <= 1'b1;
              r_ready_q   <= 1'b1;
            end
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_we_o       = rsp_we_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_resp_o     = rsp_resp_q;

  assign axi_l.aw_addr  = addr_q;
  assign axi_l.aw_valid = aw_valid_q;
  assign axi_l.w_data   = wdata_q;
  assign axi_l.w_strb   = wstrb_q;
  assign axi_l.w_valid  = w_valid_q;
  assign axi_l.b_ready  = b_ready_q;
  assign axi_l.ar_addr  = addr_q;
  assign axi_l.ar_valid = ar_valid_q;
  assign axi_l.r_ready  = r_ready_q;

endmodule
